// File: rtl/zion_riscv_int_ex_arb.sv
// Round-robin issue arbiter and one-entry result slot for the shared integer
// execute unit. One requester is granted per cycle, its bundle is driven to
// IntEx, and the combinational IntEx result is captured one edge later into a
// valid/ready output slot. After a taken branch/jump the arbiter parks in
// HOLD and issues nothing until the front end flushes.
//
// Handshakes:
//   req_vld/req_rdy : a requester transfers when req_vld[i] & req_rdy[i].
//                     req_rdy is one-hot or zero, and never depends on ex_*.
//                     A requester keeps req_vld/req_ins/req_tag steady until it
//                     is granted (a flush may withdraw pending requests).
//   out_vld/out_rdy : the slot transfers when out_vld & out_rdy. While
//                     out_vld & ~out_rdy every out_* field holds steady.

module zion_riscv_int_ex_arb #(
   parameter int RV64    = 0,
   parameter int NUM_REQ = 2,
   parameter int INS_W   = 64,
   parameter int TAG_W   = 6,
   localparam int XLEN   = 32 * (RV64 + 1),
   localparam int SRC_W  = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       req_vld,
   output logic [NUM_REQ-1:0]       req_rdy,
   input  logic [NUM_REQ*INS_W-1:0] req_ins,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [INS_W-1:0]         ex_ins,
   input  logic [XLEN-1:0]          ex_rslt,
   input  logic                     ex_bj_en,
   input  logic [XLEN-1:0]          ex_bj_tgt,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [XLEN-1:0]          out_rslt,
   output logic                     out_bj_en,
   output logic [XLEN-1:0]          out_bj_tgt,
   output logic [TAG_W-1:0]         out_tag,
   output logic [SRC_W-1:0]         out_src,
   output logic                     hold
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              out_vld_q, out_vld_d;
   logic [XLEN-1:0]   out_rslt_q, out_rslt_d;
   logic              out_bj_en_q, out_bj_en_d;
   logic [XLEN-1:0]   out_bj_tgt_q, out_bj_tgt_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;

   logic              can_issue;
   logic              hi_vld, lo_vld;
   logic [SRC_W-1:0]  hi_idx, lo_idx;
   logic              gnt_vld;
   logic [SRC_W-1:0]  gnt_idx;
   logic [TAG_W-1:0]  gnt_tag;

   // Issue is possible only when running, not flushing/resetting, and the slot
   // is empty or being emptied this cycle.
   always_comb begin
      can_issue = (state_q == ST_RUN) & ~flush & ~rst & (~out_vld_q | out_rdy);
   end

   // Round-robin pick: the lowest valid index at or above rr_ptr wins; if none
   // exists the search wraps to the lowest valid index overall. Then drive the
   // one-hot grant and mux the winner's bundle and tag (zero when idle).
   always_comb begin
      hi_vld  = 1'b0;
      hi_idx  = '0;
      lo_vld  = 1'b0;
      lo_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_vld[i]) begin
            lo_vld = 1'b1;
            lo_idx = SRC_W'(i);
            if (i >= int'(rr_ptr_q)) begin
               hi_vld = 1'b1;
               hi_idx = SRC_W'(i);
            end
         end
      end
      gnt_vld = can_issue & lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;

      req_rdy = '0;
      ex_ins  = '0;
      gnt_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_vld && (gnt_idx == SRC_W'(i))) begin
            req_rdy[i] = 1'b1;
            ex_ins     = req_ins[i*INS_W +: INS_W];
            gnt_tag    = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   // Pointer moves just past the winner on every grant and otherwise holds.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         if (gnt_idx == SRC_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + SRC_W'(1);
         end
      end
   end

   // FSM next state: a taken branch/jump issued from RUN parks the arbiter in
   // HOLD; flush always returns to RUN.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && gnt_vld && ex_bj_en) begin
         state_d = ST_HOLD;
      end
   end

   // FSM outputs.
   always_comb begin
      hold = (state_q == ST_HOLD);
   end

   // Result slot: flush drops the entry, a grant loads fresh data (possibly in
   // the same cycle the old entry is accepted), an accept alone empties it.
   // Data fields only change on a load.
   always_comb begin
      out_vld_d    = out_vld_q;
      out_rslt_d   = out_rslt_q;
      out_bj_en_d  = out_bj_en_q;
      out_bj_tgt_d = out_bj_tgt_q;
      out_tag_d    = out_tag_q;
      out_src_d    = out_src_q;
      if (flush) begin
         out_vld_d = 1'b0;
      end else if (gnt_vld) begin
         out_vld_d    = 1'b1;
         out_rslt_d   = ex_rslt;
         out_bj_en_d  = ex_bj_en;
         out_bj_tgt_d = ex_bj_tgt;
         out_tag_d    = gnt_tag;
         out_src_d    = gnt_idx;
      end else if (out_vld_q && out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointer and result slot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         out_vld_q    <= 1'b0;
         out_rslt_q   <= '0;
         out_bj_en_q  <= 1'b0;
         out_bj_tgt_q <= '0;
         out_tag_q    <= '0;
         out_src_q    <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         out_vld_q    <= out_vld_d;
         out_rslt_q   <= out_rslt_d;
         out_bj_en_q  <= out_bj_en_d;
         out_bj_tgt_q <= out_bj_tgt_d;
         out_tag_q    <= out_tag_d;
         out_src_q    <= out_src_d;
      end
   end

   always_comb begin
      out_vld    = out_vld_q;
      out_rslt   = out_rslt_q;
      out_bj_en  = out_bj_en_q;
      out_bj_tgt = out_bj_tgt_q;
      out_tag    = out_tag_q;
      out_src    = out_src_q;
   end

endmodule

// File: tb/tb_zion_riscv_int_ex_arb.sv
// Bench for zion_riscv_int_ex_arb with two requesters and a 32-bit datapath.
// A tiny IntEx stand-in decodes the bundle: s1=[15:0], s2=[31:16],
// target=[47:32], taken=[63]; result = s1 + s2.

module tb_zion_riscv_int_ex_arb;

   localparam int NUM_REQ = 2;
   localparam int INS_W   = 64;
   localparam int TAG_W   = 6;
   localparam int XLEN    = 32;

   localparam logic [63:0] OP_A = 64'h0000_0000_0007_0005;  // 5 + 7 = 12
   localparam logic [63:0] OP_B = 64'h0000_0000_0001_0009;  // 9 + 1 = 10
   localparam logic [63:0] OP_J = 64'h8000_0100_0000_0000;  // taken, tgt 0x100
   localparam logic [5:0]  T0   = 6'h11;
   localparam logic [5:0]  T1   = 6'h22;

   // clock / reset / DUT signals
   logic                     clk;
   logic                     rst;
   logic                     flush;
   logic [NUM_REQ-1:0]       req_vld;
   logic [NUM_REQ-1:0]       req_rdy;
   logic [NUM_REQ*INS_W-1:0] req_ins;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [INS_W-1:0]         ex_ins;
   logic [XLEN-1:0]          ex_rslt;
   logic                     ex_bj_en;
   logic [XLEN-1:0]          ex_bj_tgt;
   logic                     out_vld;
   logic                     out_rdy;
   logic [XLEN-1:0]          out_rslt;
   logic                     out_bj_en;
   logic [XLEN-1:0]          out_bj_tgt;
   logic [TAG_W-1:0]         out_tag;
   logic [0:0]               out_src;
   logic                     hold;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   zion_riscv_int_ex_arb #(
      .RV64(0), .NUM_REQ(NUM_REQ), .INS_W(INS_W), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_ins(req_ins), .req_tag(req_tag),
      .ex_ins(ex_ins), .ex_rslt(ex_rslt), .ex_bj_en(ex_bj_en), .ex_bj_tgt(ex_bj_tgt),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_rslt(out_rslt),
      .out_bj_en(out_bj_en), .out_bj_tgt(out_bj_tgt), .out_tag(out_tag),
      .out_src(out_src), .hold(hold)
   );

   // IntEx stand-in
   assign ex_rslt   = 32'(ex_ins[15:0]) + 32'(ex_ins[31:16]);
   assign ex_bj_en  = ex_ins[63];
   assign ex_bj_tgt = 32'(ex_ins[47:32]);

   typedef struct {
      logic        r;
      logic        f;
      logic [1:0]  vld;
      logic        ordy;
      logic [63:0] i0;
      logic [63:0] i1;
      logic [1:0]  e_rdy;
      logic        e_vld;
      logic [31:0] e_rslt;
      logic        e_src;
      logic [5:0]  e_tag;
      logic        e_bj;
      logic [31:0] e_tgt;
      logic        e_hold;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic f, input logic [1:0] vld,
                               input logic ordy, input logic [63:0] i0, input logic [63:0] i1,
                               input logic [1:0] e_rdy, input logic e_vld,
                               input logic [31:0] e_rslt, input logic e_src,
                               input logic [5:0] e_tag, input logic e_bj,
                               input logic [31:0] e_tgt, input logic e_hold);
      vec_t v;
      v.r = r; v.f = f; v.vld = vld; v.ordy = ordy; v.i0 = i0; v.i1 = i1;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_rslt = e_rslt; v.e_src = e_src;
      v.e_tag = e_tag; v.e_bj = e_bj; v.e_tgt = e_tgt; v.e_hold = e_hold;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   // Driver + checker for one cycle: drive at negedge, check the grant side
   // before the edge, check the slot and FSM after the edge.
   task automatic run_vec(input vec_t v, input int idx);
      logic [63:0] exp_ins;
      @(negedge clk);
      rst     = v.r;
      flush   = v.f;
      req_vld = v.vld;
      out_rdy = v.ordy;
      req_ins = {v.i1, v.i0};
      req_tag = {T1, T0};
      #1;
      exp_ins = (v.e_rdy == 2'b01) ? v.i0 : (v.e_rdy == 2'b10) ? v.i1 : 64'h0;
      chk("req_rdy", idx, 64'(req_rdy), 64'(v.e_rdy));
      chk("ex_ins",  idx, ex_ins, exp_ins);
      @(posedge clk);
      #1;
      chk("out_vld",    idx, 64'(out_vld),    64'(v.e_vld));
      chk("out_rslt",   idx, 64'(out_rslt),   64'(v.e_rslt));
      chk("out_src",    idx, 64'(out_src),    64'(v.e_src));
      chk("out_tag",    idx, 64'(out_tag),    64'(v.e_tag));
      chk("out_bj_en",  idx, 64'(out_bj_en),  64'(v.e_bj));
      chk("out_bj_tgt", idx, 64'(out_bj_tgt), 64'(v.e_tgt));
      chk("hold",       idx, 64'(hold),       64'(v.e_hold));
   endtask

   // Requester protocol check: a valid, ungranted request outside reset/flush
   // must still be presented unchanged on the next cycle.
   logic [1:0]  pend_q = 2'b00;
   logic [63:0] pend_ins_q [2];
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (pend_q[i]) begin
            n_checks++;
            if (!req_vld[i] || (req_ins[i*64 +: 64] !== pend_ins_q[i])) begin
               n_fail++;
               $display("FAIL req_stable req %0d: vld %0b ins %0h expected ins %0h",
                        i, req_vld[i], req_ins[i*64 +: 64], pend_ins_q[i]);
            end
         end
         pend_q[i]     <= !rst && !flush && req_vld[i] && !req_rdy[i];
         pend_ins_q[i] <= req_ins[i*64 +: 64];
      end
   end

   vec_t tbl [28];

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      req_vld = '0;
      out_rdy = 1'b0;
      req_ins = {OP_B, OP_A};
      req_tag = {T1, T0};

      //          r  f  vld    rdy  i0    i1    e_rdy  v  rslt  s  tag e_bj tgt       hold
      // reset then idle
      tbl[0]  = mk(1, 0, 2'b00, 0, OP_A, OP_B, 2'b00, 0, 0,  0, 0,  0, 0,      0);
      tbl[1]  = mk(1, 0, 2'b00, 0, OP_A, OP_B, 2'b00, 0, 0,  0, 0,  0, 0,      0);
      tbl[2]  = mk(0, 0, 2'b00, 0, OP_A, OP_B, 2'b00, 0, 0,  0, 0,  0, 0,      0);
      // round robin, full throughput
      tbl[3]  = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[4]  = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0,      0);
      tbl[5]  = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[6]  = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0,      0);
      // backpressure for 3 cycles, release grants next requester
      tbl[7]  = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[8]  = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0,      0);
      tbl[9]  = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0,      0);
      tbl[10] = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0,      0);
      tbl[11] = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0,      0);
      // requester 1 takes a jump -> HOLD until flush
      tbl[12] = mk(0, 0, 2'b11, 1, OP_A, OP_J, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[13] = mk(0, 0, 2'b11, 1, OP_A, OP_J, 2'b10, 1, 0,  1, T1, 1, 32'h100, 1);
      tbl[14] = mk(0, 0, 2'b11, 0, OP_A, OP_J, 2'b00, 1, 0,  1, T1, 1, 32'h100, 1);
      tbl[15] = mk(0, 0, 2'b11, 1, OP_A, OP_J, 2'b00, 0, 0,  1, T1, 1, 32'h100, 1);
      tbl[16] = mk(0, 1, 2'b11, 1, OP_A, OP_J, 2'b00, 0, 0,  1, T1, 1, 32'h100, 0);
      tbl[17] = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      // flush drops a stalled slot, pointer unchanged
      tbl[18] = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0,      0);
      tbl[19] = mk(0, 1, 2'b11, 0, OP_A, OP_B, 2'b00, 0, 12, 0, T0, 0, 0,      0);
      tbl[20] = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0,      0);
      // flush while consumer accepts: slot still clears
      tbl[21] = mk(0, 1, 2'b11, 1, OP_A, OP_B, 2'b00, 0, 10, 1, T1, 0, 0,      0);
      // wrap-around search, then requester 0 jumps into HOLD
      tbl[22] = mk(0, 0, 2'b01, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[23] = mk(0, 0, 2'b01, 1, OP_J, OP_B, 2'b01, 1, 0,  0, T0, 1, 32'h100, 1);
      tbl[24] = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 0,  0, T0, 1, 32'h100, 1);
      // reset mid-operation: slot, FSM and pointer all return to reset
      tbl[25] = mk(1, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 0, 0,  0, 0,  0, 0,      0);
      tbl[26] = mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0,      0);
      tbl[27] = mk(0, 0, 2'b11, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0,      0);

      for (int v = 0; v < 28; v++) begin
         run_vec(tbl[v], v);
      end

      // Hand sequence: pending requester 1 wins on release, then a lone
      // requester 0 is granted back-to-back as the search wraps.
      run_vec(mk(0, 0, 2'b11, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0, 0), 100);
      for (int k = 0; k < 3; k++) begin
         run_vec(mk(0, 0, 2'b01, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0, 0), 101 + k);
      end

      // Hand sequence: stall of random length, then accept-with-grant, then
      // a plain accept that empties the slot.
      begin
         int n_stall;
         n_stall = $urandom_range(2, 5);
         for (int k = 0; k < n_stall; k++) begin
            run_vec(mk(0, 0, 2'b01, 0, OP_A, OP_B, 2'b00, 1, 12, 0, T0, 0, 0, 0), 110 + k);
         end
      end
      run_vec(mk(0, 0, 2'b01, 1, OP_A, OP_B, 2'b01, 1, 12, 0, T0, 0, 0, 0), 120);
      run_vec(mk(0, 0, 2'b00, 1, OP_A, OP_B, 2'b00, 0, 12, 0, T0, 0, 0, 0), 121);

      // Hand sequence: reset and flush together, reset wins.
      run_vec(mk(1, 1, 2'b11, 1, OP_A, OP_B, 2'b00, 0, 0, 0, 0, 0, 0, 0), 130);
      run_vec(mk(0, 0, 2'b10, 1, OP_A, OP_B, 2'b10, 1, 10, 1, T1, 0, 0, 0), 131);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
